// File: rtl/vfu_mem_arbiter_if.sv
// Bundle of the two requester ports, the single-port SRAM side, perf counters
// and the arbiter FSM state for debug. The arbiter uses the slave modport.
interface vfu_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              v_req;
    logic              v_we;
    logic [ADDR_W-1:0] v_addr;
    logic [DATA_W-1:0] v_wdata;
    logic              v_gnt;
    logic              v_rvalid;
    logic [DATA_W-1:0] v_rdata;

    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic [DATA_W-1:0] h_rdata;

    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              perf_clr;
    logic [31:0]       perf_v_beats;
    logic [31:0]       perf_h_beats;
    logic [31:0]       perf_stall;

    logic [1:0]        dbg_state;

    // A beat transfers in the cycle where req && gnt; req side holds
    // we/addr/wdata stable until then and may drop req before gnt.
    modport slave (
        input  v_req, v_we, v_addr, v_wdata, h_req, h_we, h_addr, h_wdata,
        input  sram_rdata, perf_clr,
        output v_gnt, v_rvalid, v_rdata, h_gnt, h_rvalid, h_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        output perf_v_beats, perf_h_beats, perf_stall, dbg_state
    );

    modport master (
        output v_req, v_we, v_addr, v_wdata, h_req, h_we, h_addr, h_wdata,
        output sram_rdata, perf_clr,
        input  v_gnt, v_rvalid, v_rdata, h_gnt, h_rvalid, h_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        input  perf_v_beats, perf_h_beats, perf_stall, dbg_state
    );
endinterface

// File: rtl/vfu_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port SRAM between the
// vector core (V) and host loader (H). Perf counters exist only with VFU_ARB_PERF_EN.
module vfu_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int SRAM_LAT  = 1,
    parameter int MAX_BURST = 8
) (
    input logic               clk,
    input logic               rst_n,
    vfu_mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic OWNER_V = 1'b0;
    localparam logic OWNER_H = 1'b1;

    typedef enum logic [1:0] {IDLE = 2'd0, OWN_V = 2'd1, OWN_H = 2'd2} state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SRAM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [SRAM_LAT-1:0] tag_own_q, tag_own_d;

    logic               gnt_v, gnt_h, beat_v, beat_h, rd_strobe;
    logic               sram_we;
    logic [ADDR_W-1:0]  sram_addr;
    logic [DATA_W-1:0]  sram_wdata;
    logic               tail_vld, v_rvalid, h_rvalid;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        gnt_v      = 1'b0;
        gnt_h      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.v_req && (!bus.h_req || last_q == OWNER_H)) begin
                    gnt_v = 1'b1; state_d = OWN_V; beat_cnt_d = CNT_ONE; last_d = OWNER_V;
                end else if (bus.h_req) begin
                    gnt_h = 1'b1; state_d = OWN_H; beat_cnt_d = CNT_ONE; last_d = OWNER_H;
                end
            end
            OWN_V: begin
                if (bus.v_req && !(beat_cnt_q == CNT_MAX && bus.h_req)) begin
                    gnt_v = 1'b1;
                    if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + CNT_ONE;
                end else if (bus.h_req) begin
                    // handover in the same cycle: no bubble between owners
                    gnt_h = 1'b1; state_d = OWN_H; beat_cnt_d = CNT_ONE; last_d = OWNER_H;
                end else begin
                    state_d = IDLE; beat_cnt_d = '0;
                end
            end
            OWN_H: begin
                if (bus.h_req && !(beat_cnt_q == CNT_MAX && bus.v_req)) begin
                    gnt_h = 1'b1;
                    if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + CNT_ONE;
                end else if (bus.v_req) begin
                    gnt_v = 1'b1; state_d = OWN_V; beat_cnt_d = CNT_ONE; last_d = OWNER_V;
                end else begin
                    state_d = IDLE; beat_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // grants are combinational, so hold them low while reset is asserted
        if (!rst_n) begin
            gnt_v = 1'b0;
            gnt_h = 1'b0;
        end
    end

    assign beat_v    = bus.v_req & gnt_v;
    assign beat_h    = bus.h_req & gnt_h;
    assign rd_strobe = (beat_v | beat_h) & ~sram_we;

    always_comb begin
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (beat_v) begin
            sram_we = bus.v_we; sram_addr = bus.v_addr; sram_wdata = bus.v_wdata;
        end else if (beat_h) begin
            sram_we = bus.h_we; sram_addr = bus.h_addr; sram_wdata = bus.h_wdata;
        end
    end

    // {valid, owner} tag pipe mirrors the SRAM read latency
    always_comb begin
        tag_vld_d = (tag_vld_q << 1) | SRAM_LAT'(rd_strobe);
        tag_own_d = (tag_own_q << 1) | SRAM_LAT'(beat_h);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= OWNER_H;
            beat_cnt_q <= '0;
            tag_vld_q  <= '0;
            tag_own_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_own_q  <= tag_own_d;
        end
    end

    assign tail_vld = tag_vld_q[SRAM_LAT-1];
    assign v_rvalid = tail_vld & (tag_own_q[SRAM_LAT-1] == OWNER_V);
    assign h_rvalid = tail_vld & (tag_own_q[SRAM_LAT-1] == OWNER_H);

    assign bus.v_gnt      = gnt_v;
    assign bus.h_gnt      = gnt_h;
    assign bus.v_rvalid   = v_rvalid;
    assign bus.h_rvalid   = h_rvalid;
    assign bus.v_rdata    = v_rvalid ? bus.sram_rdata : '0;
    assign bus.h_rdata    = h_rvalid ? bus.sram_rdata : '0;
    assign bus.sram_en    = beat_v | beat_h;
    assign bus.sram_we    = sram_we;
    assign bus.sram_addr  = sram_addr;
    assign bus.sram_wdata = sram_wdata;
    assign bus.dbg_state  = state_q;

`ifdef VFU_ARB_PERF_EN
    logic [31:0] perf_v_q, perf_v_d, perf_h_q, perf_h_d, perf_stall_q, perf_stall_d;
    logic        stall;

    assign stall = (bus.v_req & ~gnt_v) | (bus.h_req & ~gnt_h);

    always_comb begin
        perf_v_d     = perf_v_q + {31'd0, beat_v};
        perf_h_d     = perf_h_q + {31'd0, beat_h};
        perf_stall_d = perf_stall_q + {31'd0, stall};
        if (bus.perf_clr) begin
            perf_v_d     = '0;
            perf_h_d     = '0;
            perf_stall_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_v_q     <= '0;
            perf_h_q     <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_v_q     <= perf_v_d;
            perf_h_q     <= perf_h_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.perf_v_beats = perf_v_q;
    assign bus.perf_h_beats = perf_h_q;
    assign bus.perf_stall   = perf_stall_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr  = bus.perf_clr;
    assign bus.perf_v_beats = 32'd0;
    assign bus.perf_h_beats = 32'd0;
    assign bus.perf_stall   = 32'd0;
`endif
endmodule

// File: tb/tb_vfu_mem_arbiter.sv
// Bench for vfu_mem_arbiter: one instance at SRAM_LAT=1 and one at SRAM_LAT=3,
// each with a small SRAM model; read returns are scored against expected queues.
`timescale 1ns/1ps
module tb_vfu_mem_arbiter;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       cyc;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cyc = '0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_v_q[$], exp_h_q[$], exp3_v_q[$], exp3_h_q[$];
    logic [2:0] gp_q[$];

    vfu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();
    vfu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b3 ();

    vfu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_LAT(1), .MAX_BURST(MAX_BURST))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    vfu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_LAT(3), .MAX_BURST(MAX_BURST))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return 64'hDEAD_BEEF_0000_0000 | {54'd0, a};
    endfunction

    // ---------------- SRAM models ----------------
    logic [DATA_W-1:0] m1 [1024];
    logic              w1 [1024];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] m3 [1024];
    logic              w3 [1024];
    logic [DATA_W-1:0] p3 [3];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) w1[i] <= 1'b0;
        end else if (b1.sram_en && b1.sram_we) begin
            m1[b1.sram_addr] <= b1.sram_wdata;
            w1[b1.sram_addr] <= 1'b1;
        end else if (b1.sram_en) begin
            rd1 <= w1[b1.sram_addr] ? m1[b1.sram_addr] : pat(b1.sram_addr);
        end
    end
    assign b1.sram_rdata = rd1;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) w3[i] <= 1'b0;
        end else if (b3.sram_en && b3.sram_we) begin
            m3[b3.sram_addr] <= b3.sram_wdata;
            w3[b3.sram_addr] <= 1'b1;
        end
        p3[0] <= (b3.sram_en && !b3.sram_we) ? (w3[b3.sram_addr] ? m3[b3.sram_addr] : pat(b3.sram_addr)) : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b3.sram_rdata = p3[2];

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [2:0] g;
        if (rst_n) begin
            if (b1.v_rvalid) begin
                if (exp_v_q.size() == 0) check("v_rvalid_unexpected", 64'(b1.v_rvalid), 64'd0);
                else begin
                    e = exp_v_q.pop_front();
                    check("v_rdata", b1.v_rdata, e.data);
                    check("v_rvalid_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (b1.h_rvalid) begin
                if (exp_h_q.size() == 0) check("h_rvalid_unexpected", 64'(b1.h_rvalid), 64'd0);
                else begin
                    e = exp_h_q.pop_front();
                    check("h_rdata", b1.h_rdata, e.data);
                    check("h_rvalid_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (gp_q.size() > 0) begin
                g = gp_q.pop_front();
                check("grant_pattern", 64'({b1.v_gnt, b1.h_gnt, b1.sram_en}), 64'(g));
            end
            if (b3.v_rvalid) begin
                if (exp3_v_q.size() == 0) check("lat3_v_rvalid_unexpected", 64'(b3.v_rvalid), 64'd0);
                else begin
                    e = exp3_v_q.pop_front();
                    check("lat3_v_rdata", b3.v_rdata, e.data);
                    check("lat3_v_rvalid_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (b3.h_rvalid) begin
                if (exp3_h_q.size() == 0) check("lat3_h_rvalid_unexpected", 64'(b3.h_rvalid), 64'd0);
                else begin
                    e = exp3_h_q.pop_front();
                    check("lat3_h_rdata", b3.h_rdata, e.data);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue1(input logic is_h, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rd);
        int   t = 0;
        logic got = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        if (is_h) begin
            b1.h_req = 1'b1; b1.h_we = we; b1.h_addr = addr; b1.h_wdata = wdata;
        end else begin
            b1.v_req = 1'b1; b1.v_we = we; b1.v_addr = addr; b1.v_wdata = wdata;
        end
        while (!got && t < 20) begin
            @(negedge clk);
            got = is_h ? b1.h_gnt : b1.v_gnt;
            if (!got) begin
                @(posedge clk); #1;
                t++;
            end
        end
        if (is_h) check("h_gnt_wait", 64'(got), 64'd1);
        else      check("v_gnt_wait", 64'(got), 64'd1);
        if (got && !we) begin
            e.data = exp_rd;
            e.cyc  = cyc + 32'd1;
            if (is_h) exp_h_q.push_back(e);
            else      exp_v_q.push_back(e);
        end
        @(posedge clk); #1;
        if (is_h) b1.h_req = 1'b0;
        else      b1.v_req = 1'b0;
    endtask

    task automatic check_perf(input string tag, input logic [31:0] v, input logic [31:0] h, input logic [31:0] s);
`ifdef VFU_ARB_PERF_EN
        check({tag, "_perf_v"}, 64'(b1.perf_v_beats), 64'(v));
        check({tag, "_perf_h"}, 64'(b1.perf_h_beats), 64'(h));
        check({tag, "_perf_stall"}, 64'(b1.perf_stall), 64'(s));
`else
        check({tag, "_perf_v_off"}, 64'(b1.perf_v_beats), 64'd0);
        check({tag, "_perf_h_off"}, 64'(b1.perf_h_beats), 64'd0);
        check({tag, "_perf_stall_off"}, 64'(b1.perf_stall), 64'd0);
        if (v + h + s == 32'hFFFF_FFFF) $display("perf expectation unused");
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        b1.v_req = 1'b1; b1.v_we = 1'b0; b1.v_addr = 10'd0; b1.v_wdata = '0;
        b1.h_req = 1'b1; b1.h_we = 1'b0; b1.h_addr = 10'd1; b1.h_wdata = '0;
        b1.perf_clr = 1'b0;
        b3.v_req = 1'b0; b3.v_we = 1'b0; b3.v_addr = '0; b3.v_wdata = '0;
        b3.h_req = 1'b0; b3.h_we = 1'b0; b3.h_addr = '0; b3.h_wdata = '0;
        b3.perf_clr = 1'b0;
        rst_n = 1'b0;

        // reset with both requesting: everything quiet
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_v_gnt", 64'(b1.v_gnt), 64'd0);
        check("rst_h_gnt", 64'(b1.h_gnt), 64'd0);
        check("rst_sram_en", 64'(b1.sram_en), 64'd0);
        check("rst_sram_bus", 64'({b1.sram_we, b1.sram_addr}), 64'd0);
        check("rst_sram_wdata", b1.sram_wdata, 64'd0);
        check("rst_rvalid", 64'({b1.v_rvalid, b1.h_rvalid}), 64'd0);
        check("rst_rdata", b1.v_rdata | b1.h_rdata, 64'd0);
        check("rst_dbg_state", 64'(b1.dbg_state), 64'd0);
        check_perf("rst", 32'd0, 32'd0, 32'd0);

        // first cycle after release: V wins the tie; H drops before its grant
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("tie_v_gnt", 64'(b1.v_gnt), 64'd1);
        check("tie_h_gnt", 64'(b1.h_gnt), 64'd0);
        e.data = pat(10'd0); e.cyc = cyc + 32'd1;
        if (b1.v_gnt) exp_v_q.push_back(e);
        @(posedge clk); #1;
        b1.v_req = 1'b0; b1.h_req = 1'b0;

        // single V read, latency 1
        issue1(1'b0, 1'b0, 10'd5, '0, 64'hDEAD_BEEF_0000_0005);

        // H alone: 20 back-to-back reads, no burst cut
        @(posedge clk); #1;
        b1.h_req = 1'b1; b1.h_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b1.h_addr = 10'(i);
            @(negedge clk);
            check("h_stream_gnt", 64'(b1.h_gnt), 64'd1);
            e.data = pat(10'(i)); e.cyc = cyc + 32'd1;
            if (b1.h_gnt) exp_h_q.push_back(e);
            @(posedge clk); #1;
        end
        b1.h_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_perf("pre_clr", 32'd2, 32'd20, 32'd1);

        @(posedge clk); #1; b1.perf_clr = 1'b1;
        @(posedge clk); #1; b1.perf_clr = 1'b0;
        @(negedge clk);
        check_perf("clr0", 32'd0, 32'd0, 32'd0);

        // both hold req for 32 cycles: 8V 8H 8V 8H, sram_en every cycle
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) gp_q.push_back(((i / 8) % 2 == 0) ? 3'b101 : 3'b011);
        b1.v_req = 1'b1; b1.v_we = 1'b1; b1.v_addr = 10'd600; b1.v_wdata = 64'h1111_2222_3333_4444;
        b1.h_req = 1'b1; b1.h_we = 1'b1; b1.h_addr = 10'd700; b1.h_wdata = 64'h5555_6666_7777_8888;
        repeat (32) @(posedge clk);
        #1;
        b1.v_req = 1'b0; b1.h_req = 1'b0;
        @(negedge clk);
        check("gp_drained", 64'(gp_q.size()), 64'd0);
        check_perf("burst", 32'd16, 32'd16, 32'd32);

        // clear wins over a simultaneous beat
        @(posedge clk); #1;
        b1.perf_clr = 1'b1;
        b1.v_req = 1'b1; b1.v_we = 1'b1; b1.v_addr = 10'd601; b1.v_wdata = 64'hABCD;
        @(posedge clk); #1;
        b1.perf_clr = 1'b0; b1.v_req = 1'b0;
        @(negedge clk);
        check_perf("clr1", 32'd0, 32'd0, 32'd0);

        // the burst writes landed
        issue1(1'b0, 1'b0, 10'd600, '0, 64'h1111_2222_3333_4444);
        issue1(1'b1, 1'b0, 10'd700, '0, 64'h5555_6666_7777_8888);
        issue1(1'b1, 1'b0, 10'd601, '0, 64'h0000_0000_0000_ABCD);

        // SRAM_LAT=3: V read then H write next cycle; only v_rvalid, 3 cycles later
        @(posedge clk); #1;
        b3.v_req = 1'b1; b3.v_we = 1'b0; b3.v_addr = 10'd7;
        b3.h_req = 1'b1; b3.h_we = 1'b1; b3.h_addr = 10'd9; b3.h_wdata = 64'hCAFE_F00D_0000_0009;
        @(negedge clk);
        check("lat3_v_gnt", 64'({b3.v_gnt, b3.h_gnt}), 64'b10);
        e.data = pat(10'd7); e.cyc = cyc + 32'd3;
        if (b3.v_gnt) exp3_v_q.push_back(e);
        @(posedge clk); #1;
        b3.v_req = 1'b0;
        @(negedge clk);
        check("lat3_h_gnt", 64'({b3.v_gnt, b3.h_gnt, b3.sram_we}), 64'b011);
        @(posedge clk); #1;
        b3.h_req = 1'b0;
        @(posedge clk); #1;
        b3.v_req = 1'b1; b3.v_we = 1'b0; b3.v_addr = 10'd9;
        @(negedge clk);
        check("lat3_rb_gnt", 64'(b3.v_gnt), 64'd1);
        e.data = 64'hCAFE_F00D_0000_0009; e.cyc = cyc + 32'd3;
        if (b3.v_gnt) exp3_v_q.push_back(e);
        @(posedge clk); #1;
        b3.v_req = 1'b0;

        repeat (8) @(posedge clk);
        @(negedge clk);
        check("v_queue_drained", 64'(exp_v_q.size()), 64'd0);
        check("h_queue_drained", 64'(exp_h_q.size()), 64'd0);
        check("lat3_v_queue_drained", 64'(exp3_v_q.size()), 64'd0);
        check("idle_state", 64'({b1.dbg_state, b3.dbg_state}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: got cycle %0d expected end of stimulus", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
